switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//   Cleans the raw slide-switch inputs SW1..SW4 before they reach the 4-input AND logic stage (A..D -> F/LD1).
//   Per channel: 2-flop synchronizer, then a stability counter that accepts a new level only after it has held for CNT_MAX clocks.
//   Also emits one-cycle rise/fall/change strobes for later sequential consumers (counters, FSMs).
// PARAMETERS
//   N_CH     4          number of switch channels
//   CNT_MAX  1_000_000  clocks a synchronized level must hold before acceptance (20 ms @ 50 MHz); legal range >= 2
//   CNT_W    $clog2(CNT_MAX)  counter width, localparam, not overridden
// PORTS
//   sys_clk   in   1     system clock, all logic on rising edge
//   sys_rst   in   1     reset, synchronous, active-high
//   sw_raw    in   N_CH  asynchronous raw switch levels; bit0=SW1 .. bit3=SW4
//   sw_db     out  N_CH  debounced levels; bit0..3 drive A..D of the AND stage
//   sw_rise   out  N_CH  1-cycle pulse, channel's sw_db went 0->1 this cycle
//   sw_fall   out  N_CH  1-cycle pulse, channel's sw_db went 1->0 this cycle
//   sw_chg    out  1     1-cycle pulse, OR of all sw_rise|sw_fall bits
// BEHAVIOUR
//   Reset (sys_rst=1 at an edge): sync flops, counters, sw_db, sw_rise, sw_fall, sw_chg all -> 0. Reset mid-count discards
//     the pending count; after release, a switch already at 1 yields sw_db=1 and a sw_rise pulse after full latency.
//   Synchronizer: s0 <= sw_raw; s1 <= s0 (per bit). Only s1 is used downstream; sw_raw never feeds logic directly.
//   Per-channel counter cnt (CNT_W bits), evaluated each edge:
//     s1 == sw_db          -> cnt <= 0 (any bounce back to the accepted level restarts the window)
//     s1 != sw_db, cnt <  CNT_MAX-1 -> cnt <= cnt+1
//     s1 != sw_db, cnt == CNT_MAX-1 -> sw_db <= s1; cnt <= 0; pulse sw_rise (s1=1) or sw_fall (s1=0)
//   Counter never exceeds CNT_MAX-1; no wrap-around possible.
//   Latency: raw level stable from before edge 1 -> s1 valid after edge 2 -> sw_db and strobe registered at edge CNT_MAX+2.
//     Strobes high for exactly one cycle, coincident with the first cycle of the new sw_db value.
//   Pulses shorter than CNT_MAX consecutive s1 cycles never change sw_db and never strobe.
//   Channels fully independent; simultaneous qualifying edges on several channels set several strobe bits in
//     the same cycle; sw_chg is a single pulse for that cycle.
//   sw_rise & sw_fall never both high for one bit. All outputs registered; no combinational path from sw_raw.
// TESTING (sim with CNT_MAX=8)
//   Reset: sys_rst=1 for 3 clocks with sw_raw=4'hF -> all outputs 0 during reset; after release sw_db=4'hF, sw_rise=4'hF,
//     sw_chg=1 for one cycle at edge 10 after release, then strobes 0.
//   Clean step: sw_raw[0] 0->1 held -> sw_db[0]=1 at edge 10 (2 sync + 8), sw_rise=4'h1 and sw_chg=1 for exactly 1 cycle.
//   Bounce: sw_raw[1] toggles 1,0,1,0 every 3 clocks then holds 1 -> no change/strobe until 10 edges after final stable 1.
//   Glitch: sw_raw[2] high for 7 clocks then low -> sw_db stays 0, no strobes, counter returns to 0.
//   Simultaneous: sw_raw 4'h0->4'hF with sw_db=0 -> sw_db=4'hF same cycle, sw_rise=4'hF, sw_chg single pulse; then 4'hF->4'h0
//     gives sw_fall=4'hF.
//   Reset mid-count: assert sys_rst at cnt=5 on ch3 -> sw_db[3]=0, no strobe; after release full 10-edge latency again.

Source files
------------

// File: rtl/switch_debounce.sv
// Debounces N_CH raw slide-switch inputs: a 2-flop synchronizer followed by a per-channel
// stability counter. Emits registered level, rise/fall strobes and a combined change pulse.
module switch_debounce #(
  parameter int N_CH    = 4,
  parameter int CNT_MAX = 1_000_000
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            sw_chg
);

  localparam int              CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [N_CH-1:0]  s0_q, s1_q;
  logic [N_CH-1:0]  db_q, db_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // A sample that matches the accepted level restarts that channel's window.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      cnt_d[ch] = '0;
      if (s1_q[ch] != db_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          db_d[ch]   = s1_q[ch];
          rise_d[ch] = s1_q[ch];
          fall_d[ch] = ~s1_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
    chg_d = |(rise_d | fall_d);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s0_q   <= '0;
      s1_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
      for (int ch = 0; ch < N_CH; ch++) cnt_q[ch] <= '0;
    end else begin
      s0_q   <= sw_raw;
      s1_q   <= s0_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
      for (int ch = 0; ch < N_CH; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  assign sw_db   = db_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
  assign sw_chg  = chg_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (CNT_MAX=8): directed scenarios plus randomized
// stimulus compared against a sliding-window reference model.
module tb_switch_debounce;

  localparam int N_CH    = 4;
  localparam int CNT_MAX = 8;
  localparam int LAT     = CNT_MAX + 2;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [N_CH-1:0] sw_raw  = '0;
  logic [N_CH-1:0] sw_db, sw_rise, sw_fall;
  logic            sw_chg;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;

  // Reference model state.
  logic [N_CH-1:0] raw_hist[$];
  logic [N_CH-1:0] win[$];
  logic [N_CH-1:0] m_db = '0, m_rise = '0, m_fall = '0;
  logic            m_chg = 1'b0;

  switch_debounce #(.N_CH(N_CH), .CNT_MAX(CNT_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .sw_raw  (sw_raw),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .sw_chg  (sw_chg)
  );

  always #5 sys_clk = ~sys_clk;

  // The synchronized level seen at edge k is the raw level sampled at edge k-2. A channel
  // flips when the last CNT_MAX synchronized samples all disagree with its accepted level.
  task automatic model_edge(input logic [N_CH-1:0] raw, input logic rst);
    logic [N_CH-1:0] s1_pre;
    bit all_diff;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
    if (rst) begin
      raw_hist.delete();
      win.delete();
      m_db = '0;
      return;
    end
    s1_pre = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
    raw_hist.push_back(raw);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    win.push_back(s1_pre);
    if (win.size() > CNT_MAX) void'(win.pop_front());
    if (win.size() == CNT_MAX) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i][ch] == m_db[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[ch]   = ~m_db[ch];
          m_rise[ch] = m_db[ch];
          m_fall[ch] = ~m_db[ch];
        end
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  task automatic step(input logic [N_CH-1:0] raw, input logic rst);
    @(negedge sys_clk);
    sw_raw  = raw;
    sys_rst = rst;
    @(posedge sys_clk);
    #1;
    edge_no++;
    model_edge(raw, rst);
  endtask

  task automatic test_reset;
    int lat = 0;
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b1);
      n_tests++;
      if ({sw_db, sw_rise, sw_fall, sw_chg} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: got db=%h rise=%h fall=%h chg=%b, expected all 0",
                 edge_no, sw_db, sw_rise, sw_fall, sw_chg);
      end
    end
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'hF, 1'b0);
      n_tests++;
      if ({sw_db, sw_rise, sw_fall, sw_chg} !== {m_db, m_rise, m_fall, m_chg}) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got db=%h rise=%h fall=%h chg=%b, expected db=%h rise=%h fall=%h chg=%b",
                 edge_no, sw_db, sw_rise, sw_fall, sw_chg, m_db, m_rise, m_fall, m_chg);
      end
      if (lat == 0 && sw_db === 4'hF) begin
        lat = e;
        n_tests++;
        if (sw_rise !== 4'hF || sw_chg !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_release_strobe: got rise=%h chg=%b, expected rise=f chg=1", sw_rise, sw_chg);
        end
      end
    end
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL reset_release_latency: got %0d edges, expected %0d", lat, LAT);
    end
  endtask

  // Holds raw at 'raw' and reports after how many edges sw_db first equals 'target'.
  task automatic run_until(input string name, input logic [N_CH-1:0] raw,
                           input logic [N_CH-1:0] target, output int lat);
    lat = 0;
    for (int e = 1; e <= LAT + 4; e++) begin
      step(raw, 1'b0);
      n_tests++;
      if ({sw_db, sw_rise, sw_fall, sw_chg} !== {m_db, m_rise, m_fall, m_chg}) begin
        n_fail++;
        $display("FAIL %s edge %0d: got db=%h rise=%h fall=%h chg=%b, expected db=%h rise=%h fall=%h chg=%b",
                 name, edge_no, sw_db, sw_rise, sw_fall, sw_chg, m_db, m_rise, m_fall, m_chg);
      end
      if (lat == 0 && sw_db === target) lat = e;
    end
  endtask

  task automatic test_clean_step;
    int lat;
    run_until("settle_low", 4'h0, 4'h0, lat);
    lat = 0;
    for (int e = 1; e <= LAT + 3; e++) begin
      step(4'h1, 1'b0);
      if (lat == 0 && sw_db[0] === 1'b1) begin
        lat = e;
        n_tests++;
        if (sw_rise !== 4'h1 || sw_fall !== 4'h0 || sw_chg !== 1'b1) begin
          n_fail++;
          $display("FAIL clean_step_strobe: got rise=%h fall=%h chg=%b, expected rise=1 fall=0 chg=1",
                   sw_rise, sw_fall, sw_chg);
        end
      end else if (lat != 0) begin
        n_tests++;
        if (sw_rise !== 4'h0 || sw_chg !== 1'b0 || sw_db !== 4'h1) begin
          n_fail++;
          $display("FAIL clean_step_after: got db=%h rise=%h chg=%b, expected db=1 rise=0 chg=0",
                   sw_db, sw_rise, sw_chg);
        end
      end
    end
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL clean_step_latency: got %0d edges, expected %0d", lat, LAT);
    end
  endtask

  task automatic test_bounce;
    int lat;
    logic [N_CH-1:0] pat;
    for (int p = 0; p < 4; p++) begin
      pat = (p % 2 == 0) ? 4'h3 : 4'h1;
      for (int k = 0; k < 3; k++) begin
        step(pat, 1'b0);
        n_tests++;
        if (sw_db !== 4'h1 || sw_chg !== 1'b0) begin
          n_fail++;
          $display("FAIL bounce_quiet edge %0d: got db=%h chg=%b, expected db=1 chg=0", edge_no, sw_db, sw_chg);
        end
      end
    end
    run_until("bounce_hold", 4'h3, 4'h3, lat);
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL bounce_latency: got %0d edges, expected %0d", lat, LAT);
    end
  endtask

  task automatic test_glitch;
    int lat;
    for (int k = 0; k < 7 + LAT + 2; k++) begin
      step((k < 7) ? 4'h7 : 4'h3, 1'b0);
      n_tests++;
      if (sw_db !== 4'h3 || sw_rise !== 4'h0 || sw_fall !== 4'h0 || sw_chg !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got db=%h rise=%h fall=%h chg=%b, expected db=3 rise=0 fall=0 chg=0",
                 edge_no, sw_db, sw_rise, sw_fall, sw_chg);
      end
    end
    run_until("glitch_then_hold", 4'h7, 4'h7, lat);
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL glitch_window_restart: got %0d edges, expected %0d", lat, LAT);
    end
  endtask

  task automatic test_simultaneous;
    int lat;
    run_until("sim_settle", 4'h0, 4'h0, lat);
    lat = 0;
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'hF, 1'b0);
      if (lat == 0 && sw_db !== 4'h0) begin
        lat = e;
        n_tests++;
        if (sw_db !== 4'hF || sw_rise !== 4'hF || sw_fall !== 4'h0 || sw_chg !== 1'b1) begin
          n_fail++;
          $display("FAIL sim_rise: got db=%h rise=%h fall=%h chg=%b, expected db=f rise=f fall=0 chg=1",
                   sw_db, sw_rise, sw_fall, sw_chg);
        end
      end else if (lat != 0) begin
        n_tests++;
        if (sw_chg !== 1'b0 || sw_rise !== 4'h0) begin
          n_fail++;
          $display("FAIL sim_single_pulse: got rise=%h chg=%b, expected rise=0 chg=0", sw_rise, sw_chg);
        end
      end
    end
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL sim_rise_latency: got %0d edges, expected %0d", lat, LAT);
    end
    lat = 0;
    for (int e = 1; e <= LAT + 2; e++) begin
      step(4'h0, 1'b0);
      if (lat == 0 && sw_db !== 4'hF) begin
        lat = e;
        n_tests++;
        if (sw_db !== 4'h0 || sw_fall !== 4'hF || sw_rise !== 4'h0 || sw_chg !== 1'b1) begin
          n_fail++;
          $display("FAIL sim_fall: got db=%h rise=%h fall=%h chg=%b, expected db=0 rise=0 fall=f chg=1",
                   sw_db, sw_rise, sw_fall, sw_chg);
        end
      end
    end
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL sim_fall_latency: got %0d edges, expected %0d", lat, LAT);
    end
  endtask

  task automatic test_reset_mid_count;
    int lat;
    // Ch3 counter reaches 5 at the 7th edge with raw held high.
    for (int k = 0; k < 7; k++) begin
      step(4'h8, 1'b0);
      n_tests++;
      if (sw_db !== 4'h0 || sw_chg !== 1'b0) begin
        n_fail++;
        $display("FAIL midcount_pre edge %0d: got db=%h chg=%b, expected db=0 chg=0", edge_no, sw_db, sw_chg);
      end
    end
    step(4'h8, 1'b1);
    n_tests++;
    if ({sw_db, sw_rise, sw_fall, sw_chg} !== 13'd0) begin
      n_fail++;
      $display("FAIL midcount_reset: got db=%h rise=%h fall=%h chg=%b, expected all 0",
               sw_db, sw_rise, sw_fall, sw_chg);
    end
    run_until("midcount_release", 4'h8, 4'h8, lat);
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL midcount_latency: got %0d edges, expected %0d", lat, LAT);
    end
  endtask

  task automatic test_random;
    logic [N_CH-1:0] raw = sw_raw;
    logic            rst;
    for (int k = 0; k < 800; k++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(9) == 0) raw[ch] = ~raw[ch];
      rst = ($urandom_range(249) == 0);
      step(raw, rst);
      n_tests++;
      if ({sw_db, sw_rise, sw_fall, sw_chg} !== {m_db, m_rise, m_fall, m_chg}) begin
        n_fail++;
        $display("FAIL random edge %0d: got db=%h rise=%h fall=%h chg=%b, expected db=%h rise=%h fall=%h chg=%b",
                 edge_no, sw_db, sw_rise, sw_fall, sw_chg, m_db, m_rise, m_fall, m_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
